uart_rx: RTL and testbench

- 8N1 UART receiver that deserialises the external rx pin into bytes and presents each byte as a one-cycle strobe to the byte queue's input (in_data/in_en).
- Sits directly upstream of the queue, and mirrors uart_tx: same parameters, same clocking, same bit order.
- Validates start and stop bits.
- Reports framing errors separately; a bad frame never reaches the queue.

---
 rtl/uart_rx_pkg.sv | 26 ++
 rtl/uart_rx_if.sv | 27 ++
 rtl/uart_rx_sync.sv | 26 ++
 rtl/uart_rx.sv | 125 ++++++++++++
 tb/tb_uart_rx.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the 8N1 UART receiver: frame shape, FSM encoding and bit-timing helpers.
package uart_rx_pkg;

  localparam int unsigned DataBits      = 8;
  localparam int unsigned StopBits      = 1;
  localparam int unsigned MinClksPerBit = 4;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StStart = 3'd1,
    StData  = 3'd2,
    StStop  = 3'd3,
    StBreak = 3'd4
  } state_e;

  function automatic int unsigned clks_per_bit(input int unsigned main_clk,
                                               input int unsigned baud);
    return main_clk / baud;
  endfunction

  function automatic int unsigned half_bit(input int unsigned main_clk,
                                           input int unsigned baud);
    return clks_per_bit(main_clk, baud) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: serial line in, byte strobe and status out towards the byte queue.
interface uart_rx_if;
  import uart_rx_pkg::*;

  logic                rx;
  logic [DataBits-1:0] data_out;
  logic                en;
  logic                frame_err;
  logic                busy;

  modport master (
    input  rx,
    output data_out,
    output en,
    output frame_err,
    output busy
  );

  modport slave (
    output rx,
    input  data_out,
    input  en,
    input  frame_err,
    input  busy
  );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer with a configurable reset value; idle-high lines reset to 1.
module uart_rx_sync #(
  parameter logic ResetVal = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= ResetVal;
      sync_q <= ResetVal;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, start/stop validation, one-cycle byte and framing strobes.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned MAIN_CLK = 12000000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic      clk,
  input  logic      rst,
  uart_rx_if.master bus
);

  localparam int unsigned N    = clks_per_bit(MAIN_CLK, BAUD);
  localparam int unsigned H    = half_bit(MAIN_CLK, BAUD);
  localparam int unsigned CntW = $clog2(N);

  localparam logic [CntW-1:0] CntBit  = CntW'(N - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(H - 1);
  localparam logic [2:0]      LastBit = 3'(DataBits - 1);

  if (N < MinClksPerBit) begin : gen_bad_baud
    $error("uart_rx: MAIN_CLK/BAUD must be at least 4 clocks per bit");
  end

  logic rx_s;

  uart_rx_sync #(
    .ResetVal (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (bus.rx),
    .q_o (rx_s)
  );

  state_e              state_q;
  logic [CntW-1:0]     cnt_q;
  logic [2:0]          bit_idx_q;
  logic [DataBits-1:0] shift_q;
  logic [DataBits-1:0] data_q;
  logic                en_q;
  logic                ferr_q;

  // Counter reloads on every state entry so each sample point is measured from T0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      en_q      <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      en_q   <= 1'b0;
      ferr_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (!rx_s) begin
            state_q <= StStart;
            cnt_q   <= CntHalf;
          end
        end
        StStart: begin
          if (cnt_q == '0) begin
            cnt_q <= CntBit;
            if (rx_s) begin
              state_q <= StIdle;
            end else begin
              state_q   <= StData;
              bit_idx_q <= '0;
            end
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StData: begin
          if (cnt_q == '0) begin
            shift_q <= {rx_s, shift_q[DataBits-1:1]};
            cnt_q   <= CntBit;
            if (bit_idx_q == LastBit) begin
              state_q <= StStop;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StStop: begin
          if (cnt_q == '0) begin
            cnt_q <= CntBit;
            if (rx_s) begin
              data_q  <= shift_q;
              en_q    <= 1'b1;
              state_q <= StIdle;
            end else begin
              ferr_q  <= 1'b1;
              state_q <= StBreak;
            end
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StBreak: begin
          // A held-low line yields a single frame_err; wait for idle before rearming.
          if (rx_s) begin
            state_q <= StIdle;
            cnt_q   <= CntHalf;
          end
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= CntHalf;
        end
      endcase
    end
  end

  assign bus.data_out  = data_q;
  assign bus.en        = en_q;
  assign bus.frame_err = ferr_q;
  assign bus.busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at N=16, H=8: timing, glitch, framing, reset abort, baud drift.
module tb_uart_rx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  int n_vec = 0;
  int n_err = 0;

  uart_rx_if bus_if ();

  uart_rx #(
    .MAIN_CLK (16),
    .BAUD     (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int         en_cnt   = 0;
  int         ferr_cnt = 0;
  int         overlap  = 0;
  int         en_at    [64];
  logic [7:0] en_data  [64];
  int         ferr_at  [64];

  always @(negedge clk) begin
    if (bus_if.en && bus_if.frame_err) overlap <= overlap + 1;
    if (bus_if.en) begin
      if (en_cnt < 64) begin
        en_at[en_cnt]   <= cyc;
        en_data[en_cnt] <= bus_if.data_out;
      end
      en_cnt <= en_cnt + 1;
    end
    if (bus_if.frame_err) begin
      if (ferr_cnt < 64) ferr_at[ferr_cnt] <= cyc;
      ferr_cnt <= ferr_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  int start_cyc;

  // Hold the current line level for the remainder of a bit period of the given length.
  task automatic drive_bit(input logic v, input int cycles);
    @(posedge clk);
    #1 bus_if.rx = v;
    repeat (cycles - 1) @(posedge clk);
  endtask

  // Frame bit j (start=0, data 1..8, stop=9) lasts pa clocks when j is even, pb when odd.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int pa, input int pb);
    @(posedge clk);
    #1 bus_if.rx = 1'b0;
    start_cyc = cyc;
    repeat (pa - 1) @(posedge clk);
    for (int j = 1; j <= 8; j++) drive_bit(b[j-1], (j % 2 == 0) ? pa : pb);
    drive_bit(stop, pb);
  endtask

  int base_en;
  int base_fe;
  int s0;

  initial begin
    bus_if.rx = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_data_out", 32'(bus_if.data_out), 32'h00);
    check("rst_en", 32'(bus_if.en), 32'h0);
    check("rst_frame_err", 32'(bus_if.frame_err), 32'h0);
    check("rst_busy", 32'(bus_if.busy), 32'h0);
    rst = 1'b0;
    repeat (5) @(posedge clk);

    // Ideal 0x55.
    base_en = en_cnt;
    base_fe = ferr_cnt;
    send_frame(8'h55, 1'b1, 16, 16);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("b55_en_count", 32'(en_cnt - base_en), 32'd1);
    check("b55_data", 32'(en_data[base_en]), 32'h55);
    check("b55_latency", 32'(en_at[base_en] - start_cyc), 32'd155);
    check("b55_no_ferr", 32'(ferr_cnt - base_fe), 32'd0);
    check("b55_busy_after", 32'(bus_if.busy), 32'h0);
    check("b55_data_out_hold", 32'(bus_if.data_out), 32'h55);

    // Three-cycle glitch: START at T0=k+3, back to IDLE at T0+8.
    base_en = en_cnt;
    base_fe = ferr_cnt;
    @(posedge clk);
    #1 bus_if.rx = 1'b0;
    repeat (2) @(posedge clk);
    @(posedge clk);
    #1 bus_if.rx = 1'b1;
    @(negedge clk);
    check("glitch_busy_t0", 32'(bus_if.busy), 32'h1);
    repeat (7) @(negedge clk);
    check("glitch_busy_t0p7", 32'(bus_if.busy), 32'h1);
    @(negedge clk);
    check("glitch_idle_t0p8", 32'(bus_if.busy), 32'h0);
    repeat (30) @(negedge clk);
    check("glitch_no_en", 32'(en_cnt - base_en), 32'd0);
    check("glitch_no_ferr", 32'(ferr_cnt - base_fe), 32'd0);
    check("glitch_data_out", 32'(bus_if.data_out), 32'h55);

    // 0x3C with a low stop bit, then the line held low as a break.
    base_en = en_cnt;
    base_fe = ferr_cnt;
    send_frame(8'h3C, 1'b0, 16, 16);
    repeat (100) @(posedge clk);
    @(negedge clk);
    check("brk_ferr_count", 32'(ferr_cnt - base_fe), 32'd1);
    check("brk_ferr_time", 32'(ferr_at[base_fe] - start_cyc), 32'd155);
    check("brk_no_en", 32'(en_cnt - base_en), 32'd0);
    check("brk_busy_held", 32'(bus_if.busy), 32'h1);
    check("brk_data_out", 32'(bus_if.data_out), 32'h55);
    @(posedge clk);
    #1 bus_if.rx = 1'b1;
    repeat (5) @(negedge clk);
    check("brk_busy_release", 32'(bus_if.busy), 32'h0);
    check("brk_single_ferr", 32'(ferr_cnt - base_fe), 32'd1);

    // Reset mid-way through data bit 4 of 0xFF, then a clean 0x81.
    base_en = en_cnt;
    base_fe = ferr_cnt;
    @(posedge clk);
    #1 bus_if.rx = 1'b0;
    repeat (15) @(posedge clk);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, 16);
    drive_bit(1'b1, 8);
    check("abort_busy_before", 32'(bus_if.busy), 32'h1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_data_out", 32'(bus_if.data_out), 32'h00);
    check("abort_en", 32'(bus_if.en), 32'h0);
    check("abort_frame_err", 32'(bus_if.frame_err), 32'h0);
    check("abort_busy", 32'(bus_if.busy), 32'h0);
    rst = 1'b0;
    repeat (30) @(posedge clk);
    check("abort_no_strobe", 32'((en_cnt - base_en) + (ferr_cnt - base_fe)), 32'd0);
    send_frame(8'h81, 1'b1, 16, 16);
    repeat (20) @(posedge clk);
    check("b81_en_count", 32'(en_cnt - base_en), 32'd1);
    check("b81_data", 32'(en_data[base_en]), 32'h81);

    // Back-to-back 0xA3, 0x00.
    base_en = en_cnt;
    base_fe = ferr_cnt;
    send_frame(8'hA3, 1'b1, 16, 16);
    s0 = start_cyc;
    send_frame(8'h00, 1'b1, 16, 16);
    repeat (20) @(posedge clk);
    check("b2b_en_count", 32'(en_cnt - base_en), 32'd2);
    check("b2b_first", 32'(en_data[base_en]), 32'hA3);
    check("b2b_second", 32'(en_data[base_en+1]), 32'h00);
    check("b2b_first_lat", 32'(en_at[base_en] - s0), 32'd155);
    check("b2b_spacing", 32'(en_at[base_en+1] - en_at[base_en]), 32'd160);
    check("b2b_no_ferr", 32'(ferr_cnt - base_fe), 32'd0);

    // 17-clock bits: either outcome allowed; let the line settle afterwards.
    send_frame(8'h96, 1'b1, 17, 17);
    repeat (40) @(posedge clk);

    // 16/17 alternating bits must still decode.
    base_en = en_cnt;
    base_fe = ferr_cnt;
    send_frame(8'h96, 1'b1, 16, 17);
    repeat (30) @(posedge clk);
    @(negedge clk);
    check("drift_en_count", 32'(en_cnt - base_en), 32'd1);
    check("drift_data", 32'(en_data[base_en]), 32'h96);
    check("drift_no_ferr", 32'(ferr_cnt - base_fe), 32'd0);
    check("drift_busy_after", 32'(bus_if.busy), 32'h0);

    check("no_en_ferr_overlap", 32'(overlap), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
